sr_reg_bank: RTL and testbench

//   WIDTH-channel bank of clocked set/reset flip-flops with a selectable resolution for the s=r=1 case.

---
 rtl/sr_bank_pkg.sv | 32 +++
 rtl/sr_cell.sv | 43 ++++
 rtl/sr_reg_bank.sv | 92 +++++++++
 tb/tb_sr_reg_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared types and next-state helper for the SR register bank.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  // Only the s=r=1 case depends on the resolution mode.
  function automatic logic sr_next(input sr_mode_e mode, input logic s, input logic r,
                                   input logic q);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = ~q;
          default:    nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: state register with complementary output and a change strobe.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter sr_mode_e MODE    = SR_RST_DOM,
  parameter logic     RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic q_chg
);

  logic q_d, q_q;
  logic chg_d, chg_q;

  always_comb begin
    q_d   = q_q;
    if (en) begin
      q_d = sr_next(MODE, s, r, q_q);
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= RST_BIT;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign q     = q_q;
  assign qbar  = ~q_q;
  assign q_chg = chg_q;

endmodule

// File: rtl/sr_reg_bank.sv
// WIDTH-channel SR register bank with conflict flag; define SR_CONFLICT_CNT_EN
// to add the saturating conflict counter (clr_cnt / conflict_cnt ports).
module sr_reg_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_chg,
  output logic             conflict
`ifdef SR_CONFLICT_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_reg_bank: MODE must be 0..3");
  end
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
    $error("sr_reg_bank: WIDTH and CNT_W must be >= 1");
  end

  localparam sr_mode_e MODE_E = sr_mode_e'(MODE[1:0]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE    (MODE_E),
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .s     (s[i]),
      .r     (r[i]),
      .q     (q[i]),
      .qbar  (qbar[i]),
      .q_chg (q_chg[i])
    );
  end

  logic conflict_d, conflict_q;

  always_comb begin
    conflict_d = en & (|(s & r));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear wins over increment; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench: one bank instance per resolution mode, all driven by shared inputs.
module tb_sr_reg_bank;

  localparam logic [7:0] RST_VAL = 8'hA5;
  localparam int         CNT_W   = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] s;
  logic [7:0] r;

  logic [7:0] q_o    [4];
  logic [7:0] qbar_o [4];
  logic [7:0] chg_o  [4];
  logic       conf_o [4];

`ifdef SR_CONFLICT_CNT_EN
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_o [4];
`endif

  int errors;
  int checks;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_reg_bank #(
      .WIDTH   (8),
      .MODE    (g),
      .RST_VAL (RST_VAL),
      .CNT_W   (CNT_W)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (s),
      .r            (r),
      .q            (q_o[g]),
      .qbar         (qbar_o[g]),
      .q_chg        (chg_o[g]),
      .conflict     (conf_o[g])
`ifdef SR_CONFLICT_CNT_EN
      ,
      .clr_cnt      (clr_cnt),
      .conflict_cnt (cnt_o[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst_i, input logic en_i, input logic [7:0] s_i,
                               input logic [7:0] r_i);
    @(negedge clk);
    rst = rst_i;
    en  = en_i;
    s   = s_i;
    r   = r_i;
    @(posedge clk);
    #1;
  endtask

  task automatic checkBank(input string tag, input int m, input logic [7:0] exp_q,
                           input logic [7:0] exp_chg, input logic exp_conf);
    checkOutput($sformatf("%s m%0d q", tag, m), {24'd0, q_o[m]}, {24'd0, exp_q});
    checkOutput($sformatf("%s m%0d qbar", tag, m), {24'd0, qbar_o[m]}, {24'd0, ~exp_q});
    checkOutput($sformatf("%s m%0d q_chg", tag, m), {24'd0, chg_o[m]}, {24'd0, exp_chg});
    checkOutput($sformatf("%s m%0d conflict", tag, m), {31'd0, conf_o[m]}, {31'd0, exp_conf});
  endtask

  logic [7:0] exp_q1 [4];
  logic [7:0] exp_c1 [4];
  logic [7:0] exp_q2 [4];
  logic [7:0] exp_c2 [4];
  logic [7:0] exp_q6 [4];
  logic [7:0] exp_c6 [4];

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    en  = 1'b0;
    s   = 8'hFF;
    r   = 8'h00;
`ifdef SR_CONFLICT_CNT_EN
    clr_cnt = 1'b1;
`endif

    // Expected results for s=r=FF starting from q=0F, per mode, over two cycles.
    exp_q1 = '{8'h0F, 8'hFF, 8'h00, 8'hF0};
    exp_c1 = '{8'h00, 8'hF0, 8'h0F, 8'hFF};
    exp_q2 = '{8'h0F, 8'hFF, 8'h00, 8'h0F};
    exp_c2 = '{8'h00, 8'h00, 8'h00, 8'hFF};
    // First conflict cycle after a reset, starting from RST_VAL.
    exp_q6 = '{8'hA5, 8'hFF, 8'h00, 8'h5A};
    exp_c6 = '{8'h00, 8'h5A, 8'hA5, 8'hFF};

    // Reset overrides en and s.
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'hFF);
    for (int m = 0; m < 4; m++) checkBank("reset", m, RST_VAL, 8'h00, 1'b0);
`ifdef SR_CONFLICT_CNT_EN
    clr_cnt = 1'b0;
    for (int m = 0; m < 4; m++) checkOutput($sformatf("reset m%0d cnt", m), {30'd0, cnt_o[m]}, 32'd0);
`endif

    applyStimulus(1'b1, 1'b1, 8'h0F, 8'h00);
    for (int m = 0; m < 4; m++) checkBank("set", m, 8'hAF, 8'h0A, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h03);
    for (int m = 0; m < 4; m++) checkBank("clear", m, 8'hAC, 8'h03, 1'b0);

    applyStimulus(1'b1, 1'b1, 8'h0F, 8'hF0);
    for (int m = 0; m < 4; m++) checkBank("load0F", m, 8'h0F, 8'hA3, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    for (int m = 0; m < 4; m++) checkBank("conf1", m, exp_q1[m], exp_c1[m], 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    for (int m = 0; m < 4; m++) checkBank("conf2", m, exp_q2[m], exp_c2[m], 1'b1);
`ifdef SR_CONFLICT_CNT_EN
    checkOutput("conf2 cnt", {30'd0, cnt_o[0]}, 32'd2);
`endif

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF);
      for (int m = 0; m < 4; m++) checkBank($sformatf("hold%0d", k), m, exp_q2[m], 8'h00, 1'b0);
`ifdef SR_CONFLICT_CNT_EN
      checkOutput($sformatf("hold%0d cnt", k), {30'd0, cnt_o[1]}, 32'd2);
`endif
    end

`ifdef SR_CONFLICT_CNT_EN
    clr_cnt = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("cnt clear", {30'd0, cnt_o[0]}, 32'd0);
    clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 8'h01, 8'h01);
      checkOutput($sformatf("cnt sat%0d", k), {30'd0, cnt_o[2]}, (k < 3) ? k + 1 : 3);
    end
    clr_cnt = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h80, 8'h80);
    checkOutput("cnt clr beats inc", {30'd0, cnt_o[0]}, 32'd0);
    checkOutput("cnt clr conflict", {31'd0, conf_o[0]}, 32'd1);
    clr_cnt = 1'b0;
`endif

    // Toggle continuously, then reset in the middle of it.
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'hFF);
    for (int m = 0; m < 4; m++) checkBank("midrst", m, RST_VAL, 8'h00, 1'b0);
`ifdef SR_CONFLICT_CNT_EN
    checkOutput("midrst cnt", {30'd0, cnt_o[3]}, 32'd0);
`endif
    applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
    for (int m = 0; m < 4; m++) checkBank("postrst", m, exp_q6[m], exp_c6[m], 1'b1);
`ifdef SR_CONFLICT_CNT_EN
    checkOutput("postrst cnt", {30'd0, cnt_o[3]}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
